// File: rtl/pprt_pkg.sv
// Shared constants and width helpers for the pipelined partial-product reduction adder.
package pprt_pkg;

  localparam int PIPE_DEPTH = 3;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Wide enough that N_IN full-scale operands cannot overflow the result.
  function automatic int out_width(input int width, input int n_in);
    return width + clog2(n_in);
  endfunction

endpackage

// File: rtl/pprt_pipe_csa_row.sv
// 3:2 carry-save compressor row built from full-adder cells, plus the adder cells it uses.
module half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b;
  assign carry = a & b;
endmodule

module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);
  logic s0, c0, c1;

  half_adder u_ha0 (.a(a),  .b(b), .sum(s0),  .carry(c0));
  half_adder u_ha1 (.a(s0), .b(c), .sum(sum), .carry(c1));

  assign carry = c0 | c1;
endmodule

module csa_row #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] sum,
  output logic [W-1:0] carry
);
  logic [W-2:0] cy;

  for (genvar i = 0; i < W - 1; i++) begin : g_fa
    full_adder u_fa (.a(a[i]), .b(b[i]), .c(c[i]), .sum(sum[i]), .carry(cy[i]));
  end

  // The top bit's carry would land beyond W bits and is dropped (modulo arithmetic).
  assign sum[W-1] = a[W-1] ^ b[W-1] ^ c[W-1];
  assign carry    = {cy, 1'b0};
endmodule

// File: rtl/pprt_pipe.sv
// Three-stage pipelined multi-operand adder: extend/mask, carry-save reduce, carry-propagate.
module pprt_pipe
  import pprt_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int N_IN   = 8,
  parameter int SIGNED = 0
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [N_IN*WIDTH-1:0]              in_data,
  input  logic [N_IN-1:0]                    in_mask,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [out_width(WIDTH, N_IN)-1:0]  out_data
);
  localparam int OUT_W = out_width(WIDTH, N_IN);

  logic             stall;
  logic [OUT_W-1:0] ext      [N_IN];
  logic [OUT_W-1:0] s1_ops   [N_IN];
  logic             s1_valid;
  logic [OUT_W-1:0] tree_sum [N_IN-1];
  logic [OUT_W-1:0] tree_cy  [N_IN-1];
  logic [OUT_W-1:0] s2_sum;
  logic [OUT_W-1:0] s2_carry;
  logic             s2_valid;

  // A single global stall: only a held result can block the pipe.
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  for (genvar k = 0; k < N_IN; k++) begin : g_ext
    logic [WIDTH-1:0] op;
    logic             sign;
    assign op     = in_data[k*WIDTH +: WIDTH];
    assign sign   = (SIGNED != 0) & op[WIDTH-1];
    assign ext[k] = in_mask[k] ? '0 : {{(OUT_W-WIDTH){sign}}, op};
  end

  // Chain of 3:2 rows folding one more operand into the (sum, carry) pair each step.
  assign tree_sum[0] = s1_ops[0];
  assign tree_cy[0]  = s1_ops[1];

  for (genvar k = 2; k < N_IN; k++) begin : g_tree
    csa_row #(.W(OUT_W)) u_csa (
      .a    (tree_sum[k-2]),
      .b    (tree_cy[k-2]),
      .c    (s1_ops[k]),
      .sum  (tree_sum[k-1]),
      .carry(tree_cy[k-1])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
      s2_sum    <= '0;
      s2_carry  <= '0;
      out_data  <= '0;
      for (int k = 0; k < N_IN; k++) s1_ops[k] <= '0;
    end else if (!stall) begin
      s1_valid <= in_valid;
      for (int k = 0; k < N_IN; k++) s1_ops[k] <= ext[k];
      s2_valid  <= s1_valid;
      s2_sum    <= tree_sum[N_IN-2];
      s2_carry  <= tree_cy[N_IN-2];
      out_valid <= s2_valid;
      out_data  <= s2_sum + s2_carry;
    end
  end

endmodule

// File: doc/pprt_pipe.md
PPRT_PIPE -- requirements
Module: pprt_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the operand width in bits (minimum 2).
REQ-002 SHALL have parameter N_IN, default 8, giving the operand count (minimum 3).
REQ-003 SHALL have parameter SIGNED, default 0; 0 means unsigned operands, 1 means two's-complement operands.
REQ-004 SHALL derive localparam OUT_W = WIDTH + clog2(N_IN), which is 19 at the defaults.
REQ-005 SHALL have port clk, input, 1 bit: the single clock, rising-edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port in_valid, input, 1 bit: the operand set is valid.
REQ-008 SHALL have port in_ready, output, 1 bit: the block accepts the operand set this cycle.
REQ-009 SHALL have port in_data, input, N_IN*WIDTH bits: operand k occupies bits [k*WIDTH +: WIDTH].
REQ-010 SHALL have port in_mask, input, N_IN bits: when bit k is 1, operand k is treated as zero.
REQ-011 SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-012 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-013 SHALL have port out_data, output, OUT_W bits: the sum of the unmasked operands.

Function
REQ-014 SHALL transfer an input when in_valid and in_ready are both 1 on a rising clk edge.
REQ-015 SHALL transfer an output when out_valid and out_ready are both 1 on a rising clk edge.
REQ-016 SHALL compute out_data as the sum of all unmasked operands, modulo 2^OUT_W.
REQ-017 SHALL, when SIGNED=1, sign-extend each operand to OUT_W before summing; when SIGNED=0, it SHALL zero-extend.
REQ-018 SHALL use a three-stage pipeline:
- S1 registers the masked, extended operands.
- S2 registers the carry-save (sum, carry) pair produced by a 3:2 compressor tree reducing N_IN rows to 2.
- S3 registers the carry-propagate sum.
REQ-019 SHALL have a latency of exactly 3 cycles from input transfer to out_valid when no stall occurs.
REQ-020 SHALL sustain a throughput of one transfer per cycle while out_ready is held at 1.
REQ-021 SHALL drive in_ready = out_ready OR NOT out_valid, combinationally, with no combinational path from in_valid.
REQ-022 SHALL freeze all stage registers and valid bits while out_valid=1 and out_ready=0 (global stall).
REQ-023 SHALL hold out_data stable while out_valid=1 and out_ready=0.
REQ-024 SHALL advance bubbles (stage valid=0) through the pipeline like data when not stalled.
REQ-025 SHALL accept a new input in the same cycle that S3 is drained (simultaneous in/out transfer) with no lost or duplicated result.
REQ-026 SHALL, when in_mask is all ones, produce a result of 0 with normal latency.
REQ-027 SHALL wrap silently on unsigned overflow, which cannot occur for unmasked worst cases at OUT_W, and SHALL set no flag.

Reset
REQ-028 SHALL, while rst_n=0, clear the S1, S2 and S3 valid bits asynchronously, driving out_valid=0 and out_data=0.
REQ-029 SHALL discard all in-flight data when reset asserts mid-operation, producing no spurious out_valid after release.
REQ-030 SHALL drive in_ready=1 during reset, because out_valid=0.
REQ-031 SHALL clear the data registers on reset, so no X values are observable on out_data.

Structure
REQ-032 SHALL place the clog2 function, the OUT_W derivation helper and the pipeline-depth constant (3) in shared package pprt_pkg.
REQ-033 SHALL instantiate the 3:2 compressor row as sub-module csa_row, with parameter W, inputs a, b, c and outputs sum and carry (carry pre-shifted left by 1).
REQ-034 SHALL build the compressor tree with generate loops over N_IN, reusing the existing full_adder and half_adder cells inside csa_row.
REQ-035 SHALL add no combinational logic on out_data after the S3 register.

Verification
REQ-036 SHALL cover: defaults, SIGNED=0, all 8 operands 0xFFFF, mask 0 -> out_data=0x7FFF8 exactly 3 cycles later.
REQ-037 SHALL cover: SIGNED=1, operand0=0xFFFF, the rest 0 -> 0x7FFFF; the same stimulus with SIGNED=0 -> 0x0FFFF.
REQ-038 SHALL cover: operands 1..8 with in_mask=0x0F -> 5+6+7+8 = 26 (0x0001A); with in_mask=0xFF -> 0.
REQ-039 SHALL cover: 10 back-to-back inputs with out_ready=0 for cycles 4-7 -> in_ready=0 in those cycles, all 10 results in order, none duplicated.
REQ-040 SHALL cover: rst_n pulsed low for 1 cycle with 3 items in flight -> out_valid stays 0 until a new input is accepted and 3 cycles elapse.
REQ-041 SHALL cover: WIDTH=8, N_IN=5, 10,000 random transactions with random masks and out_ready -> match against a reference sum, with 100% valid/ready toggle coverage.
